// File: rtl/tetris_frame_composer_if.sv
// Bundle of the composer's frame-control, field-RAM read and frame-buffer write signals.
// The master side starts frames and serves the field RAM; the slave side composes rows.
interface tetris_frame_composer_if;
   logic        frame_tick;
   logic [15:0] piece_shape;
   logic [4:0]  piece_x;
   logic [4:0]  piece_y;
   logic        field_rd_en;
   logic [3:0]  field_rd_addr;
   logic [15:0] field_rd_data;
   logic        wr_en;
   logic [3:0]  wr_row;
   logic [31:0] wr_data;
   logic        busy;
   logic        done;
   logic        collision;

   modport master (
      output frame_tick, piece_shape, piece_x, piece_y, field_rd_data,
      input  field_rd_en, field_rd_addr, wr_en, wr_row, wr_data, busy, done, collision
   );

   modport slave (
      input  frame_tick, piece_shape, piece_x, piece_y, field_rd_data,
      output field_rd_en, field_rd_addr, wr_en, wr_row, wr_data, busy, done, collision
   );
endinterface

// File: rtl/tetris_frame_composer.sv
// Overlays a 4x4 falling piece on the 16x16 field, one row per 3 cycles; done 49 cycles after frame_tick.
// No backpressure: field reads and row writes are fixed-cadence strobes; ticks while busy are dropped.
module tetris_frame_composer #(
   parameter logic [1:0] DENS_FIELD = 2'd1,
   parameter logic [1:0] DENS_PIECE = 2'd3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   tetris_frame_composer_if.slave   bus
);
   typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_t;

   state_t      state_q, state_d;
   logic [3:0]  row_q, row_d;
   logic [15:0] shape_q, shape_d;
   logic [4:0]  x_q, x_d;
   logic [4:0]  y_q, y_d;
   logic [15:0] fld_q, fld_d;
   logic        coll_q, coll_d;

   logic [15:0] pmask;
   logic        oob;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         row_q   <= '0;
         shape_q <= '0;
         x_q     <= '0;
         y_q     <= '0;
         fld_q   <= '0;
         coll_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         shape_q <= shape_d;
         x_q     <= x_d;
         y_q     <= y_d;
         fld_q   <= fld_d;
         coll_q  <= coll_d;
      end
   end

   // Piece cells on the current row; cells above the grid are silently clipped, other escapes collide.
   always_comb begin
      logic signed [5:0] gx;
      logic signed [5:0] gy;
      pmask = '0;
      oob   = 1'b0;
      gx    = '0;
      gy    = '0;
      for (int pr = 0; pr < 4; pr++) begin
         for (int pc = 0; pc < 4; pc++) begin
            gy = {y_q[4], y_q} + 6'(pr);
            gx = {x_q[4], x_q} + 6'(pc);
            if (shape_q[4*pr+pc] && !gy[5]) begin
               if (gx[5] || gx > 6'sd15 || gy > 6'sd15)
                  oob = 1'b1;
               else if (gy[3:0] == row_q)
                  pmask[gx[3:0]] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      shape_d = shape_q;
      x_d     = x_q;
      y_d     = y_q;
      fld_d   = fld_q;
      coll_d  = coll_q;
      case (state_q)
         IDLE: begin
            if (bus.frame_tick) begin
               shape_d = bus.piece_shape;
               x_d     = bus.piece_x;
               y_d     = bus.piece_y;
               coll_d  = 1'b0;
               row_d   = '0;
               state_d = READ;
            end
         end
         READ: state_d = WAIT;
         WAIT: begin
            fld_d   = bus.field_rd_data;
            state_d = WRITE;
         end
         WRITE: begin
            coll_d = coll_q | oob | (|(pmask & fld_q));
            if (row_q == 4'd15) begin
               state_d = DONE;
            end else begin
               row_d   = row_q + 4'd1;
               state_d = READ;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.wr_data = '0;
      if (state_q == WRITE) begin
         for (int c = 0; c < 16; c++) begin
            if (pmask[c])
               bus.wr_data[2*c +: 2] = DENS_PIECE;
            else if (fld_q[c])
               bus.wr_data[2*c +: 2] = DENS_FIELD;
         end
      end
   end

   assign bus.field_rd_en   = (state_q == READ);
   assign bus.field_rd_addr = row_q;
   assign bus.wr_en         = (state_q == WRITE);
   assign bus.wr_row        = row_q;
   assign bus.busy          = (state_q != IDLE);
   assign bus.done          = (state_q == DONE);
   assign bus.collision     = coll_q;
endmodule

// File: tb/tb_tetris_frame_composer.sv
// Directed bench for tetris_frame_composer: field RAM model, write logger and per-frame timing/data checks.
module tb_tetris_frame_composer;
   logic clk;
   logic rst_n;
   tetris_frame_composer_if bus ();

   tetris_frame_composer #(.DENS_FIELD(2'd1), .DENS_PIECE(2'd3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [15:0] field_mem [16];
   always @(posedge clk) begin
      if (bus.field_rd_en) bus.field_rd_data <= field_mem[bus.field_rd_addr];
   end

   // Write/done logger, sampled on the falling edge
   int          wr_cnt = 0;
   int          done_cnt = 0;
   int          done_cyc = 0;
   logic        done_coll = 1'b0;
   int          busy_start = 0;
   int          busy_end = 0;
   logic        busy_p = 1'b0;
   logic [3:0]  log_row [512];
   logic [31:0] log_dat [512];
   int          log_cyc [512];

   always @(negedge clk) begin
      if (bus.wr_en) begin
         log_row[wr_cnt] = bus.wr_row;
         log_dat[wr_cnt] = bus.wr_data;
         log_cyc[wr_cnt] = cyc;
         wr_cnt = wr_cnt + 1;
      end
      if (bus.done) begin
         done_cnt  = done_cnt + 1;
         done_cyc  = cyc;
         done_coll = bus.collision;
      end
      if (bus.busy && !busy_p) busy_start = cyc;
      if (!bus.busy && busy_p) busy_end = cyc - 1;
      busy_p = bus.busy;
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   logic [31:0] exp_rows [16];

   task automatic set_exp_field();
      for (int r = 0; r < 16; r++)
         exp_rows[r] = (field_mem[r] == 16'hFFFF) ? 32'h55555555 : 32'h0;
   endtask

   task automatic run_frame(input logic [15:0] sh, input logic [4:0] px, input logic [4:0] py,
                            input bit retick, input logic coll_exp);
      int t, wb, db;
      bit got;
      @(negedge clk); #2;
      bus.piece_shape = sh;
      bus.piece_x     = px;
      bus.piece_y     = py;
      bus.frame_tick  = 1'b1;
      t  = cyc;
      wb = wr_cnt;
      db = done_cnt;
      @(negedge clk); #2;
      bus.frame_tick = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 80 && !got; i++) begin
         if (retick && cyc == t + 10) begin
            bus.frame_tick  = 1'b1;
            bus.piece_shape = ~sh;
            bus.piece_x     = px + 5'd1;
         end else begin
            bus.frame_tick = 1'b0;
         end
         @(negedge clk); #2;
         got = (done_cnt != db);
      end
      bus.frame_tick = 1'b0;
      repeat (4) @(negedge clk);
      #2;
      check_eq("done_seen", 32'(got), 32'd1);
      check_eq("wr_count", 32'(wr_cnt - wb), 32'd16);
      check_eq("done_count", 32'(done_cnt - db), 32'd1);
      check_eq("done_cycle", 32'(done_cyc - t), 32'd49);
      check_eq("busy_first", 32'(busy_start - t), 32'd1);
      check_eq("busy_last", 32'(busy_end - t), 32'd49);
      check_eq("collision", 32'(done_coll), 32'(coll_exp));
      for (int r = 0; r < 16; r++) begin
         check_eq($sformatf("row%0d_idx", r), 32'(log_row[wb+r]), 32'(r));
         check_eq($sformatf("row%0d_dat", r), log_dat[wb+r], exp_rows[r]);
         check_eq($sformatf("row%0d_cyc", r), 32'(log_cyc[wb+r] - t), 32'(3 + 3*r));
      end
   endtask

   task automatic check_outputs_zero(input string pfx);
      check_eq({pfx, "_rd_en"},   32'(bus.field_rd_en),   32'd0);
      check_eq({pfx, "_rd_addr"}, 32'(bus.field_rd_addr), 32'd0);
      check_eq({pfx, "_wr_en"},   32'(bus.wr_en),         32'd0);
      check_eq({pfx, "_wr_row"},  32'(bus.wr_row),        32'd0);
      check_eq({pfx, "_wr_data"}, bus.wr_data,            32'd0);
      check_eq({pfx, "_busy"},    32'(bus.busy),          32'd0);
      check_eq({pfx, "_done"},    32'(bus.done),          32'd0);
      check_eq({pfx, "_coll"},    32'(bus.collision),     32'd0);
   endtask

   initial begin
      int t, wb, db;
      rst_n           = 1'b0;
      bus.frame_tick  = 1'b0;
      bus.piece_shape = '0;
      bus.piece_x     = '0;
      bus.piece_y     = '0;
      for (int r = 0; r < 16; r++) field_mem[r] = 16'h0;
      repeat (3) @(negedge clk);
      #1;
      check_outputs_zero("rst");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Empty field, empty piece
      set_exp_field();
      run_frame(16'h0000, 5'd0, 5'd0, 1'b0, 1'b0);

      // 2x2 block at the top, full bottom row
      field_mem[15] = 16'hFFFF;
      set_exp_field();
      exp_rows[0] = 32'h00000F00;
      exp_rows[1] = 32'h00000F00;
      run_frame(16'h0033, 5'd4, 5'd0, 1'b0, 1'b0);

      // Block sinking into the full row
      set_exp_field();
      exp_rows[14] = 32'h00000F00;
      exp_rows[15] = 32'h55555F55;
      run_frame(16'h0033, 5'd4, 5'd14, 1'b0, 1'b1);

      // Single cell off the left edge collides; above the top is clipped quietly
      field_mem[15] = 16'h0000;
      set_exp_field();
      run_frame(16'h0001, 5'h1F, 5'd3, 1'b0, 1'b1);
      run_frame(16'h0001, 5'd0, 5'h1F, 1'b0, 1'b0);

      // Second tick and piece change mid-frame must have no effect
      field_mem[15] = 16'hFFFF;
      set_exp_field();
      exp_rows[0] = 32'h00000F00;
      exp_rows[1] = 32'h00000F00;
      run_frame(16'h0033, 5'd4, 5'd0, 1'b1, 1'b0);

      // Reset in the middle of a frame
      @(negedge clk); #2;
      bus.piece_shape = 16'h0033;
      bus.piece_x     = 5'd4;
      bus.piece_y     = 5'd0;
      bus.frame_tick  = 1'b1;
      t  = cyc;
      wb = wr_cnt;
      db = done_cnt;
      @(negedge clk); #2;
      bus.frame_tick = 1'b0;
      for (int i = 0; i < 30 && cyc < t + 20; i++) begin
         @(negedge clk); #2;
      end
      rst_n = 1'b0;
      #1;
      check_outputs_zero("abort");
      check_eq("abort_wr_before", 32'(wr_cnt - wb), 32'd6);
      wb = wr_cnt;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      #2;
      check_eq("abort_wr_after", 32'(wr_cnt - wb), 32'd0);
      check_eq("abort_no_done", 32'(done_cnt - db), 32'd0);
      check_eq("abort_idle", 32'(bus.busy), 32'd0);

      run_frame(16'h0033, 5'd4, 5'd0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
